jdv_sequenceur: RTL and testbench

- Controller that owns the Game-of-Life grid state feeding the VGA pattern generator.
- Provides the `vecteur_map`, cursor position and `select_affichage` inputs that the display generator consumes.
- Sequences two modes, sharing the single map register between them:
  - EDIT: cursor moves and cells toggle from debounced buttons.
  - RUN: the next generation is computed serially, one cell per clock, into a shadow buffer, then committed atomically once per N frames.

---
 rtl/jdv_pkg.sv | 42 ++++
 rtl/jdv_regle_cellule.sv | 18 +
 rtl/jdv_sequenceur.sv | 143 ++++++++++++++
 tb/tb_jdv_sequenceur.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jdv_pkg.sv
// Shared grid geometry, controller state encoding and toroidal coordinate helpers
// for the Game-of-Life sequencer.
package jdv_pkg;

    localparam int LARGEUR  = 38;
    localparam int HAUTEUR  = 37;
    localparam int MAP_BITS = LARGEUR * HAUTEUR;
    localparam int CW       = 6;
    localparam int IW       = 11;

    typedef logic [CW-1:0] coord_t;
    typedef logic [IW-1:0] idx_t;

    typedef enum logic [1:0] {
        EDIT     = 2'd0,
        RUN_WAIT = 2'd1,
        COMPUTE  = 2'd2,
        COMMIT   = 2'd3
    } etat_t;

    function automatic coord_t x_moins(input coord_t x);
        return (x == '0) ? coord_t'(LARGEUR - 1) : x - coord_t'(1);
    endfunction

    function automatic coord_t x_plus(input coord_t x);
        return (x == coord_t'(LARGEUR - 1)) ? '0 : x + coord_t'(1);
    endfunction

    function automatic coord_t y_moins(input coord_t y);
        return (y == '0) ? coord_t'(HAUTEUR - 1) : y - coord_t'(1);
    endfunction

    function automatic coord_t y_plus(input coord_t y);
        return (y == coord_t'(HAUTEUR - 1)) ? '0 : y + coord_t'(1);
    endfunction

    // Constant multiply by LARGEUR reduces to shifts and adds.
    function automatic idx_t position(input coord_t x, input coord_t y);
        return idx_t'(x) + idx_t'(y) * idx_t'(LARGEUR);
    endfunction

endpackage

// File: rtl/jdv_regle_cellule.sv
// Conway rule for one cell: count the eight neighbours and decide survival or birth.
module jdv_regle_cellule (
    input  logic       cellule,
    input  logic [7:0] voisins,
    output logic       suivant
);

    logic [3:0] nb;

    always_comb begin
        nb = '0;
        for (int i = 0; i < 8; i++) begin
            nb = nb + {3'b000, voisins[i]};
        end
        suivant = (nb == 4'd3) | (cellule & (nb == 4'd2));
    end

endmodule

// File: rtl/jdv_sequenceur.sv
// Owns the displayed Life grid: cursor editing in EDIT, serial next-generation
// computation into a shadow buffer in RUN, committed whole-vector once per N frames.
module jdv_sequenceur
    import jdv_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                vga_vs,
    input  logic                btn_haut,
    input  logic                btn_bas,
    input  logic                btn_gauche,
    input  logic                btn_droite,
    input  logic                btn_toggle,
    input  logic                btn_run,
    input  logic                btn_clear,
    input  logic [3:0]          vitesse,
    output logic [MAP_BITS-1:0] vecteur_map,
    output logic [31:0]         h_position_du_curseur,
    output logic [31:0]         v_position_du_curseur,
    output logic                select_affichage,
    output logic                busy,
    output logic [15:0]         generation
);

    etat_t               etat;
    logic [MAP_BITS-1:0] shadow;
    coord_t              cx, cy;
    coord_t              px, py;
    logic [3:0]          frames;
    logic                vs_q;
    logic                stop_pending;
    logic                tick;

    coord_t              pxm, pxp, pym, pyp;
    logic [7:0]          voisins;
    logic                cellule;
    logic                cell_next;

    assign tick = vs_q & ~vga_vs;

    // Neighbour reads come only from the committed map, never from shadow.
    always_comb begin
        pxm     = x_moins(px);
        pxp     = x_plus(px);
        pym     = y_moins(py);
        pyp     = y_plus(py);
        cellule = vecteur_map[position(px, py)];
        voisins = {vecteur_map[position(pxm, pym)], vecteur_map[position(px, pym)],
                   vecteur_map[position(pxp, pym)], vecteur_map[position(pxm, py)],
                   vecteur_map[position(pxp, py)],  vecteur_map[position(pxm, pyp)],
                   vecteur_map[position(px, pyp)],  vecteur_map[position(pxp, pyp)]};
    end

    jdv_regle_cellule u_regle (
        .cellule (cellule),
        .voisins (voisins),
        .suivant (cell_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            etat             <= EDIT;
            vecteur_map      <= '0;
            shadow           <= '0;
            cx               <= '0;
            cy               <= '0;
            px               <= '0;
            py               <= '0;
            frames           <= '0;
            vs_q             <= 1'b0;
            stop_pending     <= 1'b0;
            select_affichage <= 1'b1;
            busy             <= 1'b0;
            generation       <= '0;
        end else begin
            vs_q <= vga_vs;
            case (etat)
                EDIT: begin
                    if (btn_clear) begin
                        vecteur_map <= '0;
                        generation  <= '0;
                    end else if (btn_run) begin
                        etat             <= RUN_WAIT;
                        frames           <= '0;
                        select_affichage <= 1'b0;
                    end else if (btn_toggle) begin
                        vecteur_map[position(cx, cy)] <= ~vecteur_map[position(cx, cy)];
                    end else begin
                        if (btn_gauche)      cx <= x_moins(cx);
                        else if (btn_droite) cx <= x_plus(cx);
                        if (btn_haut)        cy <= y_moins(cy);
                        else if (btn_bas)    cy <= y_plus(cy);
                    end
                end
                RUN_WAIT: begin
                    if (btn_run) begin
                        etat             <= EDIT;
                        select_affichage <= 1'b1;
                    end else if (tick) begin
                        if (frames == vitesse) begin
                            frames <= '0;
                            px     <= '0;
                            py     <= '0;
                            busy   <= 1'b1;
                            etat   <= COMPUTE;
                        end else begin
                            frames <= frames + 4'd1;
                        end
                    end
                end
                COMPUTE: begin
                    shadow[position(px, py)] <= cell_next;
                    if (btn_run) stop_pending <= 1'b1;
                    if (px == coord_t'(LARGEUR - 1)) begin
                        px <= '0;
                        if (py == coord_t'(HAUTEUR - 1)) etat <= COMMIT;
                        else                             py   <= py + coord_t'(1);
                    end else begin
                        px <= px + coord_t'(1);
                    end
                end
                COMMIT: begin
                    vecteur_map <= shadow;
                    generation  <= generation + 16'd1;
                    busy        <= 1'b0;
                    // A run press landing on the commit cycle is honoured as a stop too.
                    if (stop_pending | btn_run) begin
                        stop_pending     <= 1'b0;
                        select_affichage <= 1'b1;
                        etat             <= EDIT;
                    end else begin
                        etat <= RUN_WAIT;
                    end
                end
                default: etat <= EDIT;
            endcase
        end
    end

    assign h_position_du_curseur = {{(32 - CW){1'b0}}, cx};
    assign v_position_du_curseur = {{(32 - CW){1'b0}}, cy};

endmodule

// File: tb/tb_jdv_sequenceur.sv
// Directed bench for jdv_sequenceur: table-driven edit vectors plus hand-written
// RUN sequences checked against a bench-side Life model.
module tb_jdv_sequenceur;

    localparam int L  = 38;
    localparam int H  = 37;
    localparam int MB = L * H;

    localparam logic [6:0] B_HAUT   = 7'b0000001;
    localparam logic [6:0] B_BAS    = 7'b0000010;
    localparam logic [6:0] B_GAUCHE = 7'b0000100;
    localparam logic [6:0] B_DROITE = 7'b0001000;
    localparam logic [6:0] B_TOGGLE = 7'b0010000;
    localparam logic [6:0] B_RUN    = 7'b0100000;
    localparam logic [6:0] B_CLEAR  = 7'b1000000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          vga_vs = 1'b1;
    logic          btn_haut = 1'b0, btn_bas = 1'b0, btn_gauche = 1'b0, btn_droite = 1'b0;
    logic          btn_toggle = 1'b0, btn_run = 1'b0, btn_clear = 1'b0;
    logic [3:0]    vitesse = 4'd0;
    logic [MB-1:0] vecteur_map;
    logic [31:0]   h_position_du_curseur, v_position_du_curseur;
    logic          select_affichage, busy;
    logic [15:0]   generation;

    int n_checks = 0;
    int n_errors = 0;
    int tcx = 0;
    int tcy = 0;
    logic [MB-1:0] m_model;

    jdv_sequenceur dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .vga_vs                (vga_vs),
        .btn_haut              (btn_haut),
        .btn_bas               (btn_bas),
        .btn_gauche            (btn_gauche),
        .btn_droite            (btn_droite),
        .btn_toggle            (btn_toggle),
        .btn_run               (btn_run),
        .btn_clear             (btn_clear),
        .vitesse               (vitesse),
        .vecteur_map           (vecteur_map),
        .h_position_du_curseur (h_position_du_curseur),
        .v_position_du_curseur (v_position_du_curseur),
        .select_affichage      (select_affichage),
        .busy                  (busy),
        .generation            (generation)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [MB-1:0] life_step(input logic [MB-1:0] m);
        logic [MB-1:0] r;
        int n;
        r = '0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < L; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (dx != 0 || dy != 0)
                            n += int'(m[((x + dx + L) % L) + ((y + dy + H) % H) * L]);
                    end
                end
                if (m[x + y * L]) r[x + y * L] = (n == 2 || n == 3);
                else              r[x + y * L] = (n == 3);
            end
        end
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_map(input string name, input logic [MB-1:0] exp);
        int first;
        n_checks++;
        if (vecteur_map !== exp) begin
            n_errors++;
            first = -1;
            for (int i = MB - 1; i >= 0; i--) if (vecteur_map[i] !== exp[i]) first = i;
            $display("FAIL %s: map differs from bit %0d, got pop %0d expected pop %0d",
                     name, first, $countones(vecteur_map), $countones(exp));
        end
    endtask

    // ---------------- drivers ----------------
    task automatic apply_btn(input logic [6:0] b);
        @(negedge clk);
        btn_haut   = b[0];
        btn_bas    = b[1];
        btn_gauche = b[2];
        btn_droite = b[3];
        btn_toggle = b[4];
        btn_run    = b[5];
        btn_clear  = b[6];
        @(negedge clk);
        {btn_clear, btn_run, btn_toggle, btn_droite, btn_gauche, btn_bas, btn_haut} = '0;
    endtask

    task automatic place(input int x, input int y);
        while (tcx != x) begin apply_btn(B_DROITE); tcx = (tcx + 1) % L; end
        while (tcy != y) begin apply_btn(B_BAS);    tcy = (tcy + 1) % H; end
        apply_btn(B_TOGGLE);
        m_model[x + y * L] = ~m_model[x + y * L];
    endtask

    task automatic tick_only();
        @(negedge clk) vga_vs = 1'b0;
        @(negedge clk) vga_vs = 1'b1;
    endtask

    // Sends nticks frame ticks; the last must start COMPUTE. Returns busy length.
    task automatic do_generation(input int nticks, input bit tick_mid, output int cycles);
        for (int t = 0; t < nticks - 1; t++) begin
            tick_only();
            repeat (3) @(negedge clk);
            check($sformatf("busy_before_tick%0d", t + 1), {31'd0, busy}, 32'd0);
        end
        @(negedge clk) vga_vs = 1'b0;
        cycles = 0;
        @(negedge clk) vga_vs = 1'b1;
        while (busy && cycles < 5000) begin
            cycles++;
            if (tick_mid && cycles == 100) vga_vs = 1'b0;
            if (cycles == 101) vga_vs = 1'b1;
            @(negedge clk);
        end
    endtask

    // ---------------- edit vector table ----------------
    typedef struct {
        logic [6:0] btn;
        int         ex;
        int         ey;
        logic       esel;
        int         bidx;
        logic       ebit;
        int         epop;
    } vec_t;

    vec_t tab [26];

    initial begin
        int cyc;
        int guard;

        tab[0]  = '{7'd0,                0,  0,  1'b1, 79, 1'b0, 0};
        tab[1]  = '{B_DROITE,            1,  0,  1'b1, 79, 1'b0, 0};
        tab[2]  = '{B_DROITE,            2,  0,  1'b1, 79, 1'b0, 0};
        tab[3]  = '{B_DROITE,            3,  0,  1'b1, 79, 1'b0, 0};
        tab[4]  = '{B_BAS,               3,  1,  1'b1, 79, 1'b0, 0};
        tab[5]  = '{B_BAS,               3,  2,  1'b1, 79, 1'b0, 0};
        tab[6]  = '{B_TOGGLE,            3,  2,  1'b1, 79, 1'b1, 1};
        tab[7]  = '{B_TOGGLE,            3,  2,  1'b1, 79, 1'b0, 0};
        tab[8]  = '{B_TOGGLE,            3,  2,  1'b1, 79, 1'b1, 1};
        tab[9]  = '{B_GAUCHE,            2,  2,  1'b1, 79, 1'b1, 1};
        tab[10] = '{B_GAUCHE,            1,  2,  1'b1, 79, 1'b1, 1};
        tab[11] = '{B_GAUCHE,            0,  2,  1'b1, 79, 1'b1, 1};
        tab[12] = '{B_HAUT,              0,  1,  1'b1, 79, 1'b1, 1};
        tab[13] = '{B_HAUT,              0,  0,  1'b1, 79, 1'b1, 1};
        tab[14] = '{B_GAUCHE,            37, 0,  1'b1, 79, 1'b1, 1};
        tab[15] = '{B_HAUT,              37, 36, 1'b1, 79, 1'b1, 1};
        tab[16] = '{B_DROITE,            0,  36, 1'b1, 79, 1'b1, 1};
        tab[17] = '{B_BAS,               0,  0,  1'b1, 79, 1'b1, 1};
        tab[18] = '{B_TOGGLE | B_RUN,    0,  0,  1'b0, 0,  1'b0, 1};
        tab[19] = '{B_TOGGLE,            0,  0,  1'b0, 0,  1'b0, 1};
        tab[20] = '{B_DROITE,            0,  0,  1'b0, 79, 1'b1, 1};
        tab[21] = '{B_CLEAR,             0,  0,  1'b0, 79, 1'b1, 1};
        tab[22] = '{B_RUN,               0,  0,  1'b1, 79, 1'b1, 1};
        tab[23] = '{B_CLEAR | B_RUN,     0,  0,  1'b1, 79, 1'b0, 0};
        tab[24] = '{B_TOGGLE | B_DROITE, 0,  0,  1'b1, 0,  1'b1, 1};
        tab[25] = '{B_CLEAR,             0,  0,  1'b1, 0,  1'b0, 0};

        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_gen", {16'd0, generation}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            apply_btn(tab[i].btn);
            check($sformatf("row%0d_x", i), h_position_du_curseur, tab[i].ex);
            check($sformatf("row%0d_y", i), v_position_du_curseur, tab[i].ey);
            check($sformatf("row%0d_sel", i), {31'd0, select_affichage}, {31'd0, tab[i].esel});
            check($sformatf("row%0d_bit", i), {31'd0, vecteur_map[tab[i].bidx]}, {31'd0, tab[i].ebit});
            check($sformatf("row%0d_pop", i), $countones(vecteur_map), tab[i].epop);
        end

        // Blinker, one generation at vitesse 0
        tcx = 0; tcy = 0; m_model = '0;
        place(10, 5); place(11, 5); place(12, 5);
        check_map("blinker_setup", m_model);
        vitesse = 4'd0;
        apply_btn(B_RUN);
        check("blinker_sel_run", {31'd0, select_affichage}, 32'd0);
        do_generation(1, 1'b0, cyc);
        check("blinker_busy_cycles", cyc, 1407);
        m_model = life_step(m_model);
        check_map("blinker_gen1", m_model);
        check("blinker_pop", $countones(vecteur_map), 3);
        check("blinker_b163", {31'd0, vecteur_map[163]}, 32'd1);
        check("blinker_b201", {31'd0, vecteur_map[201]}, 32'd1);
        check("blinker_b239", {31'd0, vecteur_map[239]}, 32'd1);
        check("blinker_gen", {16'd0, generation}, 32'd1);

        // Glider across the corner, vitesse 1, a tick dropped during each COMPUTE
        apply_btn(B_RUN);
        check("glider_back_edit", {31'd0, select_affichage}, 32'd1);
        apply_btn(B_CLEAR);
        check("glider_clear_gen", {16'd0, generation}, 32'd0);
        m_model = '0;
        place(37, 35); place(0, 36); place(36, 0); place(37, 0); place(0, 0);
        check_map("glider_setup", m_model);
        vitesse = 4'd1;
        apply_btn(B_RUN);
        for (int g = 1; g <= 8; g++) begin
            do_generation(2, 1'b1, cyc);
            m_model = life_step(m_model);
            check($sformatf("glider_g%0d_cycles", g), cyc, 1407);
            check_map($sformatf("glider_g%0d_map", g), m_model);
            check($sformatf("glider_g%0d_pop", g), $countones(vecteur_map), 5);
            check($sformatf("glider_g%0d_gen", g), {16'd0, generation}, g);
        end

        // run pressed mid-COMPUTE: the generation still commits, then EDIT
        vitesse = 4'd0;
        tick_only();
        check("stop_busy_start", {31'd0, busy}, 32'd1);
        repeat (500) @(negedge clk);
        btn_run = 1'b1;
        @(negedge clk);
        btn_run = 1'b0;
        check("stop_busy_mid", {31'd0, busy}, 32'd1);
        guard = 0;
        while (busy && guard < 3000) begin guard++; @(negedge clk); end
        check("stop_busy_done", {31'd0, busy}, 32'd0);
        m_model = life_step(m_model);
        check_map("stop_map", m_model);
        check("stop_gen", {16'd0, generation}, 32'd9);
        check("stop_sel", {31'd0, select_affichage}, 32'd1);
        tick_only();
        repeat (3) @(negedge clk);
        check("stop_edit_no_compute", {31'd0, busy}, 32'd0);

        // Asynchronous reset at idx ~700 of COMPUTE
        apply_btn(B_RUN);
        tick_only();
        repeat (699) @(negedge clk);
        check("rst_busy_before", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_pop", $countones(vecteur_map), 0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sel", {31'd0, select_affichage}, 32'd1);
        check("rst_x", h_position_du_curseur, 32'd0);
        check("rst_y", v_position_du_curseur, 32'd0);
        check("rst_gen", {16'd0, generation}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick_only();
        repeat (3) @(negedge clk);
        check("rst_edit_no_compute", {31'd0, busy}, 32'd0);
        apply_btn(B_TOGGLE);
        check("rst_edit_toggle", {31'd0, vecteur_map[0]}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
